// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract: one CW-bit chunk resolved per stage, carry registered between stages.
// Valid/ready handshakes on both sides; a stalled output freezes the whole pipe.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C_out,
    output logic             V
);

    localparam int CW = WIDTH / STAGES;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    logic              stall;
    logic              adv;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [WIDTH-1:0]  b_eff;
    logic              cin0;

    assign stall     = vld_q[STAGES-1] & ~out_ready;
    assign adv       = ~stall;
    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES-1];

    assign b_eff = SUB ? ~B : B;
    assign cin0  = SUB | C_in;

    // Bubbles travel with the data; nothing is compressed.
    assign vld_d = (vld_q << 1) | STAGES'(in_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q <= vld_d;
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stg
        localparam int IW = WIDTH - s * CW;   // operand bits still unconsumed on entry
        localparam int RW = (s + 1) * CW;     // result bits held after this stage

        logic [IW-1:0] a_in;
        logic [IW-1:0] b_in;
        logic          cy_in;
        logic [CW-1:0] a_c;
        logic [CW-1:0] b_c;
        logic [CW:0]   sum_c;
        logic [RW-1:0] res_d;
        logic [RW-1:0] res_q;
        logic          cy_q;

        if (s == 0) begin : g_src
            assign a_in  = A;
            assign b_in  = b_eff;
            assign cy_in = cin0;
            assign res_d = sum_c[CW-1:0];
        end else begin : g_src
            assign a_in  = g_stg[s-1].g_ops.a_q;
            assign b_in  = g_stg[s-1].g_ops.b_q;
            assign cy_in = g_stg[s-1].cy_q;
            assign res_d = {sum_c[CW-1:0], g_stg[s-1].res_q};
        end

        assign a_c   = a_in[CW-1:0];
        assign b_c   = b_in[CW-1:0];
        assign sum_c = {1'b0, a_c} + {1'b0, b_c} + {{CW{1'b0}}, cy_in};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                res_q <= '0;
                cy_q  <= 1'b0;
            end else if (adv) begin
                res_q <= res_d;
                cy_q  <= sum_c[CW];
            end
        end

        if (IW > CW) begin : g_ops
            logic [IW-CW-1:0] a_q;
            logic [IW-CW-1:0] b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[IW-1:CW];
                    b_q <= b_in[IW-1:CW];
                end
            end
        end

        if (s == STAGES - 1) begin : g_last
            logic v_q;

            // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= 1'b0;
                end else if (adv) begin
                    v_q <= sum_c[CW] ^ (a_c[CW-1] ^ b_c[CW-1] ^ sum_c[CW-1]);
                end
            end
        end
    end

    assign S     = g_stg[STAGES-1].res_q;
    assign C_out = g_stg[STAGES-1].cy_q;
    assign V     = g_stg[STAGES-1].g_last.v_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: 32/4 directed, streaming, reset cases; 8/1 and 8/8 exhaustive sweep.
module tb_pipelined_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        iv32, ir32, sub32, cin32, ov32, or32, c32, v32;
    logic [31:0] a32, b32, s32;
    logic        iv1, ir1, sub1, cin1, ov1, or1, c1, v1;
    logic [7:0]  a1, b1, s1;
    logic        iv8, ir8, sub8, cin8, ov8, or8, c8, v8;
    logic [7:0]  a8, b8, s8;

    int vectors = 0;
    int errors  = 0;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .SUB(sub32), .A(a32), .B(b32),
        .C_in(cin32), .out_valid(ov32), .out_ready(or32), .S(s32), .C_out(c32), .V(v32));
    pipelined_adder #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .SUB(sub1), .A(a1), .B(b1),
        .C_in(cin1), .out_valid(ov1), .out_ready(or1), .S(s1), .C_out(c1), .V(v1));
    pipelined_adder #(.WIDTH(8), .STAGES(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .SUB(sub8), .A(a8), .B(b8),
        .C_in(cin8), .out_valid(ov8), .out_ready(or8), .S(s8), .C_out(c8), .V(v8));

    typedef struct { logic [31:0] s; bit c; bit v; } res32_t;
    typedef struct { logic [7:0] s; bit c; bit v; int t; } res8_t;
    typedef struct { bit sub; logic [31:0] a; logic [31:0] b; bit cin; logic [31:0] s; bit c; bit v; } dir_t;

    // Reference: integer arithmetic on unsigned and signed interpretations of the operands.
    function automatic void ref_op(input int w, input bit sub, input longint a, input longint b,
                                   input bit cin, output longint s, output bit c, output bit v);
        longint m, h, full, sa, sb, r;
        m = longint'(1) << w;
        h = m / 2;
        if (sub) begin
            full = a - b;
            c    = (a >= b);
        end else begin
            full = a + b + longint'(cin);
            c    = (full >= m);
        end
        s  = (full + m) % m;
        sa = (a >= h) ? a - m : a;
        sb = (b >= h) ? b - m : b;
        r  = sub ? sa - sb : sa + sb + longint'(cin);
        v  = (r >= h) || (r < -h);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iv32 = 0; sub32 = 0; a32 = '0; b32 = '0; cin32 = 0; or32 = 0;
        iv1 = 0;  sub1 = 0;  a1 = '0;  b1 = '0;  cin1 = 0;  or1 = 0;
        iv8 = 0;  sub8 = 0;  a8 = '0;  b8 = '0;  cin8 = 0;  or8 = 0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (ov32 !== 1'b0) begin errors++; $display("FAIL reset_out_valid32 got %b exp 0", ov32); end
        vectors++; if ({c32, v32, s32} !== 34'd0) begin errors++; $display("FAIL reset_outputs32 got c=%b v=%b s=%h exp all 0", c32, v32, s32); end
        vectors++; if (ov1 !== 1'b0 || s1 !== 8'd0) begin errors++; $display("FAIL reset_out1 got v=%b s=%h exp 0", ov1, s1); end
        vectors++; if (ov8 !== 1'b0 || s8 !== 8'd0) begin errors++; $display("FAIL reset_out8 got v=%b s=%h exp 0", ov8, s8); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        vectors++; if (ir32 !== 1'b1) begin errors++; $display("FAIL reset_in_ready32 got %b exp 1", ir32); end
        vectors++; if (ir1 !== 1'b1 || ir8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready8 got %b/%b exp 1/1", ir1, ir8); end
    endtask

    task automatic test_directed();
        dir_t dt[8];
        int   lat;
        dt[0] = '{0, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 1, 0};
        dt[1] = '{0, 32'h7FFFFFFF, 32'h00000001, 0, 32'h80000000, 0, 1};
        dt[2] = '{0, 32'h00000001, 32'h00000001, 1, 32'h00000003, 0, 0};
        dt[3] = '{1, 32'h00000005, 32'h00000007, 0, 32'hFFFFFFFE, 0, 0};
        dt[4] = '{1, 32'h00000005, 32'h00000007, 1, 32'hFFFFFFFE, 0, 0};
        dt[5] = '{1, 32'h00000007, 32'h00000005, 0, 32'h00000002, 1, 0};
        dt[6] = '{1, 32'h80000000, 32'h00000001, 0, 32'h7FFFFFFF, 1, 1};
        dt[7] = '{1, 32'h00000000, 32'h00000000, 1, 32'h00000000, 1, 0};
        or32 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sub32 = dt[i].sub; a32 = dt[i].a; b32 = dt[i].b; cin32 = dt[i].cin;
            iv32 = 1'b1;
            tick();
            iv32 = 1'b0;
            lat = 1;
            while (ov32 !== 1'b1 && lat < 20) begin
                tick();
                lat++;
            end
            vectors++; if (lat != 4) begin errors++; $display("FAIL dir%0d_latency got %0d exp 4", i, lat); end
            vectors++; if (s32 !== dt[i].s) begin errors++; $display("FAIL dir%0d_sum got %h exp %h", i, s32, dt[i].s); end
            vectors++; if (c32 !== dt[i].c) begin errors++; $display("FAIL dir%0d_cout got %b exp %b", i, c32, dt[i].c); end
            vectors++; if (v32 !== dt[i].v) begin errors++; $display("FAIL dir%0d_ovf got %b exp %b", i, v32, dt[i].v); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] opa[10], opb[10];
        bit          ops[10], opc[10];
        res32_t      q[$];
        res32_t      e, hold;
        longint      es;
        bit          ec, ev, stall_exp;
        int          issued, got;
        issued = 0;
        got    = 0;
        for (int i = 0; i < 10; i++) begin
            opa[i] = $urandom(); opb[i] = $urandom(); ops[i] = 1'($urandom()); opc[i] = 1'($urandom());
        end
        for (int t = 0; t < 60 && got < 10; t++) begin
            stall_exp = (t >= 6 && t <= 8);
            or32 = !stall_exp;
            iv32 = (issued < 10);
            if (issued < 10) begin
                a32 = opa[issued]; b32 = opb[issued]; sub32 = ops[issued]; cin32 = opc[issued];
            end
            #1;
            vectors++; if (ir32 !== !stall_exp) begin errors++; $display("FAIL stream_in_ready t=%0d got %b exp %b", t, ir32, !stall_exp); end
            if (t >= 4) begin
                vectors++; if (ov32 !== 1'b1) begin errors++; $display("FAIL stream_out_valid t=%0d got %b exp 1", t, ov32); end
            end
            if (t == 6) hold = '{s32, c32, v32};
            if (t == 7 || t == 8) begin
                vectors++;
                if ({s32, c32, v32} !== {hold.s, hold.c, hold.v}) begin
                    errors++; $display("FAIL stream_hold t=%0d got %h/%b/%b exp %h/%b/%b", t, s32, c32, v32, hold.s, hold.c, hold.v);
                end
            end
            if (ov32 === 1'b1 && or32) begin
                vectors++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL stream_extra t=%0d got result %h exp none", t, s32);
                end else begin
                    e = q.pop_front();
                    if ({s32, c32, v32} !== {e.s, e.c, e.v}) begin
                        errors++; $display("FAIL stream_result%0d got %h/%b/%b exp %h/%b/%b", got, s32, c32, v32, e.s, e.c, e.v);
                    end
                end
                got++;
            end
            if (iv32 && ir32 === 1'b1) begin
                ref_op(32, sub32, a32, b32, cin32, es, ec, ev);
                q.push_back('{32'(es), ec, ev});
                issued++;
            end
            tick();
        end
        vectors++; if (got != 10) begin errors++; $display("FAIL stream_count got %0d exp 10", got); end
        iv32 = 1'b0;
        or32 = 1'b1;
        for (int t = 0; t < 6; t++) begin
            vectors++; if (ov32 !== 1'b0) begin errors++; $display("FAIL stream_no_dup t=%0d got %b exp 0", t, ov32); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        longint es;
        bit     ec, ev;
        int     lat;
        or32 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a32 = $urandom(); b32 = $urandom(); sub32 = 1'($urandom()); cin32 = 1'($urandom());
            iv32 = 1'b1;
            tick();
        end
        iv32 = 1'b0;
        vectors++; if (ov32 !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got %b exp 1", ov32); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (ov32 !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b exp 0", ov32); end
        vectors++; if ({s32, c32, v32} !== 34'd0) begin errors++; $display("FAIL rstmid_outputs got %h/%b/%b exp 0/0/0", s32, c32, v32); end
        vectors++; if (ir32 !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b exp 1", ir32); end
        tick();
        @(negedge clk);
        rst  = 1'b0;
        or32 = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tick();
            vectors++; if (ov32 !== 1'b0) begin errors++; $display("FAIL rstmid_stale t=%0d got %b exp 0", t, ov32); end
        end
        a32 = $urandom(); b32 = $urandom(); sub32 = 1'b0; cin32 = 1'b1;
        ref_op(32, sub32, a32, b32, cin32, es, ec, ev);
        iv32 = 1'b1;
        tick();
        iv32 = 1'b0;
        lat = 1;
        while (ov32 !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        vectors++; if (lat != 4) begin errors++; $display("FAIL rstmid_latency got %0d exp 4", lat); end
        vectors++;
        if ({s32, c32, v32} !== {32'(es), ec, ev}) begin
            errors++; $display("FAIL rstmid_next got %h/%b/%b exp %h/%b/%b", s32, c32, v32, 32'(es), ec, ev);
        end
        tick();
    endtask

    task automatic test_sweep();
        localparam int N = 65536 + 1024;
        res8_t  q1[$], q8[$];
        res8_t  e;
        longint es;
        bit     ec, ev;
        or1 = 1'b1;
        or8 = 1'b1;
        for (int t = 0; t < N + 12; t++) begin
            iv1 = (t < N);
            iv8 = (t < N);
            if (t < 65536) begin
                a1 = t[7:0]; b1 = t[15:8]; sub1 = 1'b0; cin1 = 1'($urandom());
                a8 = t[7:0]; b8 = t[15:8]; sub8 = 1'b1; cin8 = 1'($urandom());
            end else if (t < N) begin
                a1 = 8'($urandom()); b1 = 8'($urandom()); sub1 = 1'b1; cin1 = 1'($urandom());
                a8 = 8'($urandom()); b8 = 8'($urandom()); sub8 = 1'b0; cin8 = 1'($urandom());
            end
            #1;
            if (ov1 === 1'b1) begin
                vectors++;
                if (q1.size() == 0) begin
                    errors++; $display("FAIL sweep1_extra t=%0d got %h exp none", t, s1);
                end else begin
                    e = q1.pop_front();
                    if ({s1, c1, v1} !== {e.s, e.c, e.v}) begin
                        errors++; $display("FAIL sweep1_result t=%0d got %h/%b/%b exp %h/%b/%b", t, s1, c1, v1, e.s, e.c, e.v);
                    end
                    vectors++;
                    if (t - e.t != 1) begin errors++; $display("FAIL sweep1_latency got %0d exp 1", t - e.t); end
                end
            end
            if (ov8 === 1'b1) begin
                vectors++;
                if (q8.size() == 0) begin
                    errors++; $display("FAIL sweep8_extra t=%0d got %h exp none", t, s8);
                end else begin
                    e = q8.pop_front();
                    if ({s8, c8, v8} !== {e.s, e.c, e.v}) begin
                        errors++; $display("FAIL sweep8_result t=%0d got %h/%b/%b exp %h/%b/%b", t, s8, c8, v8, e.s, e.c, e.v);
                    end
                    vectors++;
                    if (t - e.t != 8) begin errors++; $display("FAIL sweep8_latency got %0d exp 8", t - e.t); end
                end
            end
            if (iv1 && ir1 === 1'b1) begin
                ref_op(8, sub1, a1, b1, cin1, es, ec, ev);
                q1.push_back('{8'(es), ec, ev, t});
            end
            if (iv8 && ir8 === 1'b1) begin
                ref_op(8, sub8, a8, b8, cin8, es, ec, ev);
                q8.push_back('{8'(es), ec, ev, t});
            end
            tick();
        end
        vectors++;
        if (q1.size() != 0 || q8.size() != 0) begin
            errors++; $display("FAIL sweep_drain got %0d/%0d pending exp 0/0", q1.size(), q8.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
